// File: rtl/sequence_detect_controller.sv
// ----------------------------------------------------------------------------
// sequence_detect_controller
//
// Serial pattern detector with a run controller. A pattern of 1..MAX_LEN bits
// is configured while idle; after start, every qualified input bit is shifted
// into a history register and compared against the pattern (overlapping
// matches count). Each match pulses `detected` and bumps `hit_cnt`; reaching a
// nonzero hit target completes the run with a `done` pulse.
//
// Optional feature: define SEQUENCE_DETECT_CONTROLLER_TIMEOUT_EN to build an
// 8-bit inactivity counter that ends an armed run after 255 edges without a
// qualified bit. Without it the `timeout` port is tied low.
//
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   cfg_valid    configuration offered
//   cfg_ready    high in IDLE; configuration accepted with cfg_valid
//   cfg_pattern  pattern, bit [len-1] received first, bit [0] last
//   cfg_len      pattern length (0 -> 1, >MAX_LEN -> MAX_LEN)
//   cfg_count    hits to complete a run, 0 = run until abort
//   start        arm detection (IDLE only)
//   abort        stop an armed run
//   a, a_valid   serial data bit and its qualifier
//   detected     one-cycle match pulse
//   busy         high while ARMED
//   done         one-cycle run-complete pulse
//   timeout      one-cycle timeout pulse
//   hit_cnt      matches in the current or last run
// ----------------------------------------------------------------------------
module sequence_detect_controller #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic [CNT_W-1:0]   cfg_count,
    input  logic               start,
    input  logic               abort,
    input  logic               a,
    input  logic               a_valid,
    output logic               detected,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   hit_cnt
);

    localparam int SEEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [MAX_LEN-1:0] r_pattern, w_pattern_nxt;
    logic [3:0]         r_len, w_len_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic [MAX_LEN-1:0] r_hist, w_hist_nxt;
    logic [SEEN_W-1:0]  r_seen, w_seen_nxt;
    logic [CNT_W-1:0]   r_hit, w_hit_nxt;
    logic               r_detected, w_detected_nxt;
    logic               r_done, w_done_nxt;

    logic [MAX_LEN-1:0] w_shift;
    logic [SEEN_W-1:0]  w_seen_inc;
    logic [CNT_W-1:0]   w_hit_inc;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;

    // Length clamp: zero means a single bit, anything longer than the
    // history register is truncated to its full width.
    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        if (len == 4'd0)
            return 4'd1;
        else if (int'(len) > MAX_LEN)
            return 4'(MAX_LEN);
        else
            return len;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_hit(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [SEEN_W-1:0] sat_inc_seen(input logic [SEEN_W-1:0] v);
        return (v == SEEN_W'(MAX_LEN)) ? v : v + SEEN_W'(1);
    endfunction

    assign w_shift    = {r_hist[MAX_LEN-2:0], a};
    assign w_seen_inc = sat_inc_seen(r_seen);
    assign w_hit_inc  = sat_inc_hit(r_hit);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            w_mask[i] = (i < int'(r_len));
    end

    // Match is judged on the history as it will be after this bit is shifted
    // in, and only once enough bits have arrived to fill the pattern.
    assign w_match = (((w_shift ^ r_pattern) & w_mask) == '0) &&
                     (int'(w_seen_inc) >= int'(r_len));

`ifdef SEQUENCE_DETECT_CONTROLLER_TIMEOUT_EN
    logic [7:0] r_idle, w_idle_nxt;
    logic       r_timeout, w_timeout_nxt;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_pattern_nxt  = r_pattern;
        w_len_nxt      = r_len;
        w_count_nxt    = r_count;
        w_hist_nxt     = r_hist;
        w_seen_nxt     = r_seen;
        w_hit_nxt      = r_hit;
        w_detected_nxt = 1'b0;
        w_done_nxt     = 1'b0;
`ifdef SEQUENCE_DETECT_CONTROLLER_TIMEOUT_EN
        w_idle_nxt     = r_idle;
        w_timeout_nxt  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                // A configuration write wins over a simultaneous start.
                if (cfg_valid) begin
                    w_pattern_nxt = cfg_pattern;
                    w_len_nxt     = clamp_len(cfg_len);
                    w_count_nxt   = cfg_count;
                end else if (start) begin
                    w_state_nxt = ARMED;
                    w_hit_nxt   = '0;
                    w_hist_nxt  = '0;
                    w_seen_nxt  = '0;
`ifdef SEQUENCE_DETECT_CONTROLLER_TIMEOUT_EN
                    w_idle_nxt  = '0;
`endif
                end
            end
            ARMED: begin
                // Abort discards the bit on this edge, even a completing one.
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (a_valid) begin
                    w_hist_nxt = w_shift;
                    w_seen_nxt = w_seen_inc;
`ifdef SEQUENCE_DETECT_CONTROLLER_TIMEOUT_EN
                    w_idle_nxt = '0;
`endif
                    if (w_match) begin
                        w_detected_nxt = 1'b1;
                        w_hit_nxt      = w_hit_inc;
                        if ((r_count != '0) && (w_hit_inc == r_count)) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = DONE;
                        end
                    end
                end
`ifdef SEQUENCE_DETECT_CONTROLLER_TIMEOUT_EN
                else begin
                    w_idle_nxt = r_idle + 8'd1;
                    if (r_idle == 8'd254) begin
                        w_state_nxt   = IDLE;
                        w_timeout_nxt = 1'b1;
                    end
                end
`endif
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern  <= '0;
            r_len      <= 4'd1;
            r_count    <= '0;
            r_seen     <= '0;
            r_hit      <= '0;
            r_detected <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_pattern  <= w_pattern_nxt;
            r_len      <= w_len_nxt;
            r_count    <= w_count_nxt;
            r_seen     <= w_seen_nxt;
            r_hit      <= w_hit_nxt;
            r_detected <= w_detected_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // History is pure data; it is cleared on every start before it is used.
    always_ff @(posedge clk) begin
        r_hist <= w_hist_nxt;
    end

`ifdef SEQUENCE_DETECT_CONTROLLER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_idle    <= w_idle_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign cfg_ready = (r_state == IDLE);
    assign busy      = (r_state == ARMED);
    assign detected  = r_detected;
    assign done      = r_done;
    assign hit_cnt   = r_hit;

endmodule

// File: tb/tb_sequence_detect_controller.sv
// ----------------------------------------------------------------------------
// Bench for sequence_detect_controller. Directed stimulus pushes the expected
// pulse record (detected/done/timeout/hit_cnt) into a queue before driving the
// bit that should cause it; an independent monitor pops and compares every
// time the DUT raises a pulse. Level checks on busy/cfg_ready/hit_cnt are made
// directly by the stimulus thread one time unit after the clock edge.
// ----------------------------------------------------------------------------
module tb_sequence_detect_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [7:0] cfg_count;
    logic       start;
    logic       abort;
    logic       a;
    logic       a_valid;
    logic       detected;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [7:0] hit_cnt;

    typedef struct packed {
        logic       det;
        logic       dn;
        logic       to;
        logic [7:0] hc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    sequence_detect_controller #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_count(cfg_count),
        .start(start), .abort(abort), .a(a), .a_valid(a_valid),
        .detected(detected), .busy(busy), .done(done), .timeout(timeout),
        .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every pulse the DUT raises must match the next expected record.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && (detected === 1'b1 || done === 1'b1 || timeout === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got det=%b done=%b to=%b hit=%0d, required no pulse",
                         detected, done, timeout, hit_cnt);
            end else begin
                e = exp_q.pop_front();
                check("pulse", {19'd0, detected, done, timeout, hit_cnt}, {19'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input logic det, input logic dn, input logic to, input logic [7:0] hc);
        exp_q.push_back('{det: det, dn: dn, to: to, hc: hc});
    endtask

    task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic [7:0] c);
        cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_count = c;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic bit_in(input logic b, input logic v);
        a = b; a_valid = v;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] s10;
        logic [6:0] s7;
        logic [7:0] s8;

        rst = 1'b1; cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_count = 0;
        start = 0; abort = 0; a = 0; a_valid = 0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_pulses", {detected, done, timeout}, 0);

        // Reset configuration is pattern 0, len 1, count 0.
        do_start();
        check("default_armed", busy, 1);
        expect_pulse(1, 0, 0, 1);
        bit_in(1'b0, 1'b1);
        bit_in(1'b1, 1'b1);
        do_abort();
        check("default_hit", hit_cnt, 1);
        check("abort_idle", busy, 0);

        // Mid-run reset abandons the run.
        configure(8'h33, 4'd6, 8'd0);
        do_start();
        s10 = 10'b1100110000;
        for (int i = 9; i >= 4; i--) begin
            if (i == 4) expect_pulse(1, 0, 0, 1);
            bit_in(s10[i], 1'b1);
        end
        bit_in(1'b0, 1'b1);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_pulses", {detected, done}, 0);
        check("midrst_hit", hit_cnt, 0);
        check("midrst_cfg_ready", cfg_ready, 1);

        // Pattern 0x33 len 6 count 2: hits after bits 6 and 10, then done.
        configure(8'h33, 4'd6, 8'd2);
        do_start();
        s10 = 10'b1100110011;
        for (int i = 9; i >= 0; i--) begin
            if (i == 4) expect_pulse(1, 0, 0, 1);
            if (i == 0) expect_pulse(1, 1, 0, 2);
            bit_in(s10[i], 1'b1);
        end
        check("run_done_busy", busy, 0);
        check("run_done_cfg_ready", cfg_ready, 0);
        check("run_done_hit", hit_cnt, 2);
        tick();
        check("run_idle_cfg_ready", cfg_ready, 1);
        check("run_idle_hit", hit_cnt, 2);

        // Pattern 1010 len 4 count 0 with gaps; gap bits are inverted and
        // must be ignored. A start while armed must not clear hit_cnt.
        configure(8'h0A, 4'd4, 8'd0);
        do_start();
        s7 = 7'b1010101;
        for (int i = 6; i >= 0; i--) begin
            if (i == 3) expect_pulse(1, 0, 0, 1);
            if (i == 1) expect_pulse(1, 0, 0, 2);
            bit_in(s7[i], 1'b1);
            if (i == 3) start = 1'b1;
            bit_in(~s7[i], 1'b0);
            start = 1'b0;
            if (i == 3) check("start_ignored_hit", hit_cnt, 1);
        end
        check("gap_busy", busy, 1);
        check("gap_hit", hit_cnt, 2);
        do_abort();
        check("gap_abort_busy", busy, 0);
        tick();
        check("idle_hold_hit", hit_cnt, 2);

        // Abort coincides with the second completing bit.
        configure(8'h33, 4'd6, 8'd2);
        do_start();
        s10 = 10'b1100110011;
        for (int i = 9; i >= 1; i--) begin
            if (i == 4) expect_pulse(1, 0, 0, 1);
            bit_in(s10[i], 1'b1);
        end
        abort = 1'b1;
        bit_in(s10[0], 1'b1);
        abort = 1'b0;
        check("abort_win_busy", busy, 0);
        check("abort_win_cfg_ready", cfg_ready, 1);
        check("abort_win_hit", hit_cnt, 1);
        tick();

        // cfg_valid and start together: config taken, start dropped.
        cfg_valid = 1'b1; start = 1'b1;
        cfg_pattern = 8'h05; cfg_len = 4'd3; cfg_count = 8'd1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        check("cfg_start_busy", busy, 0);
        do_start();
        check("cfg_then_start_busy", busy, 1);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        expect_pulse(1, 1, 0, 1);
        bit_in(1'b1, 1'b1);
        check("len3_done_busy", busy, 0);
        tick();

        // Length 0 behaves as length 1.
        configure(8'h01, 4'd0, 8'd1);
        do_start();
        bit_in(1'b0, 1'b1);
        expect_pulse(1, 1, 0, 1);
        bit_in(1'b1, 1'b1);
        tick();

        // Length 15 is clamped to 8.
        configure(8'hA5, 4'd15, 8'd1);
        do_start();
        s8 = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) expect_pulse(1, 1, 0, 1);
            bit_in(s8[i], 1'b1);
        end
        check("len_clamp_hit", hit_cnt, 1);
        tick();

        // Inactivity while armed.
        configure(8'h00, 4'd1, 8'd0);
        do_start();
        a = 1'b0; a_valid = 1'b0;
`ifdef SEQUENCE_DETECT_CONTROLLER_TIMEOUT_EN
        expect_pulse(0, 0, 1, 0);
        repeat (254) tick();
        check("to_before_busy", busy, 1);
        tick();
        check("to_pulse", timeout, 1);
        check("to_busy", busy, 0);
        check("to_hit", hit_cnt, 0);
`else
        repeat (260) tick();
        check("no_to_busy", busy, 1);
        check("no_to_timeout", timeout, 0);
        do_abort();
`endif
        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
